// File: rtl/adiv5_arbiter.sv
// Two-requester arbiter in front of the single ADIv5 command/response FIFO pair.
// Round-robin command issue with R0 lock, requester-ID tag FIFO for in-order response routing.
module adiv5_arbiter #(
  parameter int CMD_W     = 36,
  parameter int RESP_W    = 35,
  parameter int TAG_DEPTH = 8
) (
  input  logic                             CLK,
  input  logic                             RESETn,
  // Requester side
  input  logic [CMD_W-1:0]                 R0_WRDATA,
  input  logic                             R0_WREN,
  output logic                             R0_WRFULL,
  input  logic                             R0_LOCK,
  output logic [RESP_W-1:0]                R0_RDDATA,
  output logic                             R0_RDEMPTY,
  input  logic                             R0_RDEN,
  input  logic [CMD_W-1:0]                 R1_WRDATA,
  input  logic                             R1_WREN,
  output logic                             R1_WRFULL,
  output logic [RESP_W-1:0]                R1_RDDATA,
  output logic                             R1_RDEMPTY,
  input  logic                             R1_RDEN,
  // adiv5_mux side
  output logic [CMD_W-1:0]                 DN_WRDATA,
  output logic                             DN_WREN,
  input  logic                             DN_WRFULL,
  input  logic [RESP_W-1:0]                DN_RDDATA,
  output logic                             DN_RDEN,
  input  logic                             DN_RDEMPTY,
  // Status
  output logic [$clog2(TAG_DEPTH+1)-1:0]   OUTSTANDING,
  output logic                             ERR_ORPHAN,
  output logic                             ERR_BADRD
);

  // FIFO-style handshakes on every interface: a push (WREN) transfers only in a cycle
  // where the matching FULL is low, a pop (RDEN) transfers only where EMPTY is low;
  // both take effect on the rising clock edge that samples them.

  localparam int AW = $clog2(TAG_DEPTH);
  localparam int CW = $clog2(TAG_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(TAG_DEPTH);

  logic [1:0]           r_hold_v;
  logic [CMD_W-1:0]     r_hold_d [2];
  logic                 r_rr;
  logic                 r_lock;
  logic [TAG_DEPTH-1:0] r_tag_mem;
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic                 r_err_orphan;
  logic                 r_err_badrd;

  logic [1:0]           w_wren;
  logic [CMD_W-1:0]     w_wrdata [2];
  logic [1:0]           w_cand;
  logic                 w_can_issue;
  logic                 w_issue;
  logic                 w_winner;
  logic                 w_tag_empty;
  logic                 w_tag_head;
  logic                 w_rdempty0;
  logic                 w_rdempty1;
  logic                 w_pop;
  logic                 w_orphan;
  logic                 w_badrd;

  assign w_wren      = {R1_WREN, R0_WREN};
  assign w_wrdata[0] = R0_WRDATA;
  assign w_wrdata[1] = R1_WRDATA;

  // While locked, R1 is masked out so R0 keeps the port for its whole sequence.
  assign w_cand      = {r_hold_v[1] & ~r_lock, r_hold_v[0]};
  assign w_can_issue = !DN_WRFULL && (r_count < DEPTH_C);
  assign w_winner    = r_rr ? w_cand[1] : !w_cand[0];
  assign w_issue     = w_can_issue && (|w_cand);

  assign w_tag_empty = (r_count == '0);
  assign w_tag_head  = r_tag_mem[r_rd_ptr];
  assign w_rdempty0  = DN_RDEMPTY | w_tag_empty | w_tag_head;
  assign w_rdempty1  = DN_RDEMPTY | w_tag_empty | !w_tag_head;
  assign w_pop       = (R0_RDEN & !w_rdempty0) | (R1_RDEN & !w_rdempty1);
  // A response with no tag behind it is drained so it cannot block the queue.
  assign w_orphan    = !DN_RDEMPTY & w_tag_empty;
  assign w_badrd     = (R0_RDEN & w_rdempty0) | (R1_RDEN & w_rdempty1);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_hold_v    <= '0;
      r_hold_d[0] <= '0;
      r_hold_d[1] <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (w_wren[n] && !r_hold_v[n]) begin
          r_hold_v[n] <= 1'b1;
          r_hold_d[n] <= w_wrdata[n];
        end else if (w_issue && (w_winner == 1'(n))) begin
          r_hold_v[n] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_rr   <= 1'b0;
      r_lock <= 1'b0;
    end else begin
      if (w_issue) r_rr <= ~w_winner;
      if (!R0_LOCK)                   r_lock <= 1'b0;
      else if (w_issue && !w_winner)  r_lock <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_tag_mem <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
    end else begin
      if (w_issue) begin
        r_tag_mem[r_wr_ptr] <= w_winner;
        r_wr_ptr            <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_issue, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_err_orphan <= 1'b0;
      r_err_badrd  <= 1'b0;
    end else begin
      if (w_orphan) r_err_orphan <= 1'b1;
      if (w_badrd)  r_err_badrd  <= 1'b1;
    end
  end

  assign R0_WRFULL   = r_hold_v[0];
  assign R1_WRFULL   = r_hold_v[1];
  assign R0_RDEMPTY  = w_rdempty0;
  assign R1_RDEMPTY  = w_rdempty1;
  assign R0_RDDATA   = DN_RDDATA;
  assign R1_RDDATA   = DN_RDDATA;
  assign DN_WREN     = w_issue;
  assign DN_WRDATA   = r_hold_d[w_winner];
  assign DN_RDEN     = w_pop | w_orphan;
  assign OUTSTANDING = r_count;
  assign ERR_ORPHAN  = r_err_orphan;
  assign ERR_BADRD   = r_err_badrd;

endmodule
